simcomp_core: RTL
=================

Name: simcomp_core

Overview:
- Parametrised successor to the first simple-computer block: a multi-cycle, single-issue processor with on-chip unified program/data memory and a register file.
- Runs a FETCH/DECODE/OPFETCH/EXEC state machine that decodes operands generally from the instruction word; operand addresses are never fixed per opcode.
- Adds control flow (JMP, JZ), HALT, illegal-opcode trap, an external program-load port and debug read ports.
- Sits at the top of the simcomp teaching-CPU subsystem; the bench drives it directly.

Parameters:
- DATA_W, 16, data/instruction word width; must be >= 16.
- DEPTH, 64, memory words; power of two, <= 4096.
- NREGS, 4, register count; power of two, 2..4.
- RESET_PC, 10, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary.
- prog_we  in  1  memory write strobe; honoured only in IDLE or HALTED.
- prog_addr  in  AW  program/debug address; AW = clog2(DEPTH).
- prog_wdata  in  DATA_W  program write data.
- dbg_rdata  out  DATA_W  combinational mem[prog_addr].
- dbg_rsel  in  clog2(NREGS)  register-file debug select.
- dbg_rval  out  DATA_W  combinational R[dbg_rsel].
- PC  out  AW  program counter.
- IR  out  DATA_W  instruction register.
- MBR  out  DATA_W  memory buffer register.
- MAR  out  AW  memory address register.
- halted  out  1  core is in the HALTED state.
- illegal  out  1  sticky; set when an undefined opcode is decoded.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, MAR=RESET_PC, IR=0, MBR=0, all R=0, halted=0, illegal=0, state=IDLE.
  - Memory contents are not reset.
  - Reset asserted mid-instruction abandons that instruction. A STORE whose EXEC edge has not yet occurred does not write.
- Instruction format:
  - [15:12] opcode.
  - [9:8] register select; upper bits ignored when NREGS<4.
  - [AW-1:0] address; IR bits [11:AW] ignored, so addresses wrap modulo DEPTH.
- Opcodes:
  - 0 NOP
  - 3 ADD: R += mem[a]
  - 6 SUB: R -= mem[a]
  - 7 LOAD: R = mem[a]
  - B STORE: mem[a] = R
  - 8 JMP: PC = a
  - 9 JZ: if R==0 then PC = a
  - F HALT
  - Any other opcode: illegal=1 and go to HALTED.
- Arithmetic: modulo 2^DATA_W; no flags; overflow wraps.
- States:
  - IDLE: if run=1 -> FETCH (MAR<=PC); else remain.
  - FETCH: IR<=mem[MAR]; PC<=PC+1 (wraps DEPTH-1 -> 0); -> DECODE.
  - DECODE: MAR<=IR[AW-1:0]. Then by opcode:
    - ADD/SUB/LOAD/STORE -> OPFETCH.
    - NOP -> boundary.
    - JMP: PC<=addr -> boundary.
    - JZ: PC<=addr if R[sel]==0 -> boundary.
    - HALT or illegal opcode -> HALTED.
  - OPFETCH: MBR<=mem[MAR] for ADD/SUB/LOAD; MBR<=R[sel] for STORE; -> EXEC.
  - EXEC: register write (LOAD/ADD/SUB) or mem[MAR]<=MBR (STORE); -> boundary.
  - Boundary: if run=1 -> FETCH with MAR<=updated PC; else IDLE.
  - HALTED: remain until reset; run is ignored.
- Latency: memory ops take 4 cycles FETCH->EXEC; NOP/JMP/JZ take 2; HALT takes 2 cycles to reach HALTED.
- run is sampled only in IDLE and at boundaries. Deasserting run mid-instruction completes that instruction.
- prog_we outside IDLE/HALTED is ignored.
- Same-edge STORE and prog_we cannot collide, because prog_we is gated by state.
- Memory reads are asynchronous; all register and memory writes are synchronous.

Decomposition:
- simcomp_pkg holds:
  - opcode localparams (OP_NOP=4'h0, OP_ADD=4'h3, OP_SUB=4'h6, OP_LOAD=4'h7, OP_STORE=4'hB, OP_JMP=4'h8, OP_JZ=4'h9, OP_HALT=4'hF);
  - the state encoding (IDLE, FETCH, DECODE, OPFETCH, EXEC, HALTED);
  - instruction field bit positions.
- One sub-module, simcomp_regfile: NREGS x DATA_W, one write port, two async read ports (sel, dbg), async reset to zero.

Test Plan:
- Program load and run:
  - Stimulus: rst_n=0 then 1, run=0. Load mem[10..14]={7014,3015,6016,B017,F000} and mem[20..23]={9,4,3,0}. Set run=1.
  - Required: halted after 19 cycles; R0=10, mem[23]=10, PC=15, illegal=0.
- Branch:
  - Stimulus: mem[10]=7014 with mem[20]=0, mem[11]=900D, mem[13]=F000.
  - Required: JZ taken, PC=13, then HALTED. Repeat with mem[20]=5: not taken, executes mem[12].
- Illegal opcode:
  - Stimulus: mem[10]=1000.
  - Required: illegal=1 and halted=1 after 2 cycles; R and memory unchanged.
- Stop and resume:
  - Stimulus: drop run during OPFETCH of an ADD.
  - Required: ADD completes, state IDLE, PC=next. prog_we during FETCH is ignored (mem unchanged). Re-asserting run resumes correctly.
- Wrap and reset:
  - Stimulus: place JMP 3F at 10 and NOP at 63.
  - Required: PC wraps 63 -> 0.
  - Stimulus: pulse rst_n low during EXEC of a STORE.
  - Required: target word unchanged; PC=10, IR=0, MBR=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/simcomp_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for the
// simcomp multi-cycle teaching CPU.
package simcomp_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'h7;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int SEL_LSB = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPFETCH,
        S_EXEC,
        S_HALTED
    } state_t;

    function automatic logic is_memop(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/simcomp_regfile.sv
// NREGS x DATA_W register file: one synchronous write port, two async read
// ports (operand select and debug), cleared by async reset.
module simcomp_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4,
    localparam int RSW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RSW-1:0]    wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RSW-1:0]    rsel,
    output logic [DATA_W-1:0] rdata,
    input  logic [RSW-1:0]    dsel,
    output logic [DATA_W-1:0] ddata
);

    logic [NREGS-1:0][DATA_W-1:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  r <= '0;
        else if (we) r[wsel] <= wdata;
    end

    assign rdata = r[rsel];
    assign ddata = r[dsel];

endmodule

// File: rtl/simcomp_core.sv
// Multi-cycle single-issue CPU: FETCH/DECODE/OPFETCH/EXEC over a unified
// async-read memory, with program-load and debug ports.
module simcomp_core
    import simcomp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 64,
    parameter int NREGS    = 4,
    parameter int RESET_PC = 10,
    localparam int AW      = $clog2(DEPTH),
    localparam int RSW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic [RSW-1:0]    dbg_rsel,
    output logic [DATA_W-1:0] dbg_rval,
    output logic [AW-1:0]     PC,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MBR,
    output logic [AW-1:0]     MAR,
    output logic              halted,
    output logic              illegal
);

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;

    logic [3:0]        op;
    logic [AW-1:0]     addr;
    logic [RSW-1:0]    sel;
    logic [DATA_W-1:0] rval;
    logic [AW-1:0]     npc;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    assign op        = IR[OPC_MSB:OPC_LSB];
    assign addr      = IR[AW-1:0];
    assign sel       = IR[SEL_LSB +: RSW];
    assign dbg_rdata = mem[prog_addr];

    // Next PC at a control-flow boundary leaving DECODE
    assign npc = ((op == OP_JMP) || (op == OP_JZ && rval == '0)) ? addr : PC;

    assign rf_we = (state == S_EXEC) &&
                   (op == OP_ADD || op == OP_SUB || op == OP_LOAD);

    always_comb begin
        rf_wdata = MBR;
        case (op)
            OP_ADD:  rf_wdata = rval + MBR;
            OP_SUB:  rf_wdata = rval - MBR;
            default: rf_wdata = MBR;
        endcase
    end

    simcomp_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .wsel  (sel),
        .wdata (rf_wdata),
        .rsel  (sel),
        .rdata (rval),
        .dsel  (dbg_rsel),
        .ddata (dbg_rval)
    );

    // Program writes are state-gated, so they never coincide with a STORE
    always_ff @(posedge clk) begin
        if (state == S_EXEC && op == OP_STORE)
            mem[MAR] <= MBR;
        else if (prog_we && (state == S_IDLE || state == S_HALTED))
            mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            PC      <= AW'(RESET_PC);
            MAR     <= AW'(RESET_PC);
            IR      <= '0;
            MBR     <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (run) begin
                    state <= S_FETCH;
                    MAR   <= PC;
                end
                S_FETCH: begin
                    IR    <= mem[MAR];
                    PC    <= PC + 1'b1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    MAR <= addr;
                    if (is_memop(op)) begin
                        state <= S_OPFETCH;
                    end else if (op == OP_NOP || op == OP_JMP || op == OP_JZ) begin
                        PC    <= npc;
                        state <= run ? S_FETCH : S_IDLE;
                        if (run) MAR <= npc;
                    end else begin
                        illegal <= illegal | (op != OP_HALT);
                        halted  <= 1'b1;
                        state   <= S_HALTED;
                    end
                end
                S_OPFETCH: begin
                    MBR   <= (op == OP_STORE) ? rval : mem[MAR];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= run ? S_FETCH : S_IDLE;
                    if (run) MAR <= PC;
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule
